// File: rtl/rv_serializer.sv
// Wide-to-narrow ready/valid serializer: accepts one IN_WIDTH word and emits it
// as RATIO beats of OUT_WIDTH bits, flagging the final beat with last_out.
module rv_serializer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic                 ready_in,
  output logic                 valid_out,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 last_out,
  input  logic                 ready_out
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  generate
    if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_ratio
      $error("rv_serializer: IN_WIDTH must be an exact multiple (>= 2x) of OUT_WIDTH");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_r, state_s;
  logic [IN_WIDTH-1:0]    word_r;
  logic [CNT_W-1:0]       count_r;
  logic [OUT_WIDTH-1:0]   data_r;
  logic                   ready_s;
  logic                   last_s;
  logic                   in_hs_s;
  logic                   out_hs_s;
  logic                   load_s;
  logic                   adv_s;
  logic                   done_s;

  // Beat index idx of word w, honouring the configured slice order.
  function automatic logic [OUT_WIDTH-1:0] slice_f(input logic [IN_WIDTH-1:0] w,
                                                   input logic [CNT_W-1:0]    idx);
    logic [CNT_W-1:0] pos;
    pos = (LSB_FIRST != 0) ? idx : (CNT_LAST - idx);
    slice_f = w[pos*OUT_WIDTH +: OUT_WIDTH];
  endfunction

  // Handshake decode and next-state selection.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    adv_s    = 1'b0;
    done_s   = 1'b0;
    last_s   = (state_r == BUSY) && (count_r == CNT_LAST);
    if (reset) begin
      ready_s = 1'b0;
    end else if (state_r == IDLE) begin
      ready_s = 1'b1;
    end else begin
      ready_s = last_s && ready_out;
    end
    in_hs_s  = valid_in && ready_s;
    out_hs_s = (state_r == BUSY) && ready_out;
    case (state_r)
      IDLE: begin
        if (in_hs_s) begin
          state_s = BUSY;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (out_hs_s && last_s) begin
          // A word arriving on the final beat reloads in place: no bubble.
          if (in_hs_s) begin
            state_s = BUSY;
            load_s  = 1'b1;
          end else begin
            state_s = IDLE;
            done_s  = 1'b1;
          end
        end else if (out_hs_s) begin
          adv_s = 1'b1;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, word, beat counter and registered output beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      word_r  <= {IN_WIDTH{1'b0}};
      count_r <= CNT_ZERO;
      data_r  <= {OUT_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      if (load_s) begin
        word_r  <= data_in;
        count_r <= CNT_ZERO;
        data_r  <= slice_f(data_in, CNT_ZERO);
      end else if (adv_s) begin
        count_r <= count_r + CNT_ONE;
        data_r  <= slice_f(word_r, count_r + CNT_ONE);
      end else if (done_s) begin
        count_r <= CNT_ZERO;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign ready_in  = ready_s;
  assign valid_out = (state_r == BUSY);
  assign data_out  = data_r;
  assign last_out  = last_s;

endmodule

// File: tb/tb_rv_serializer.sv
// Bench for rv_serializer: directed vector table, MS-first sequence, and
// randomized handshakes against a word-level beat queue model.
module tb_rv_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, ready_out, ready_in, valid_out, last_out;
  logic [31:0] data_in;
  logic [7:0]  data_out;
  logic        valid_in1, ready_out1, ready_in1, valid_out1, last_out1;
  logic [31:0] data_in1;
  logic [7:0]  data_out1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
    .last_out(last_out), .ready_out(ready_out)
  );

  rv_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .reset(reset), .valid_in(valid_in1), .data_in(data_in1),
    .ready_in(ready_in1), .valid_out(valid_out1), .data_out(data_out1),
    .last_out(last_out1), .ready_out(ready_out1)
  );

  typedef struct {
    logic        rst;
    logic        vi;
    logic [31:0] din;
    logic        ro;
    logic        e_rdy;
    logic        e_vo;
    logic [7:0]  e_do;
    logic        cd;
    logic        e_last;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  vec_t  tbl[$];
  beat_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic vi, input logic [31:0] din, input logic ro,
                     input logic e_rdy, input logic e_vo, input logic [7:0] e_do,
                     input logic cd, input logic e_last);
    vec_t v;
    v.rst = rst; v.vi = vi; v.din = din; v.ro = ro;
    v.e_rdy = e_rdy; v.e_vo = e_vo; v.e_do = e_do; v.cd = cd; v.e_last = e_last;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] msb_exp [4];
    logic       exp_rdy;
    int         lasts_dut;
    int         lasts_model;
    int         guard;

    msb_exp[0] = 8'h11; msb_exp[1] = 8'h22; msb_exp[2] = 8'h33; msb_exp[3] = 8'h44;
    lasts_dut = 0;
    lasts_model = 0;

    // rst vi din ro | rdy vo dout cd last
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    // single word, LS slice first
    add(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hCC, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 8'hDD, 1'b1, 1'b1);
    // back-to-back words, no bubble
    add(1'b0, 1'b1, 32'h03020100, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h07060504, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h07060504, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h07060504, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h07060504, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h06, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b1);
    // backpressure on beat BB, then on last beat with valid_in pending
    add(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hCC, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b1);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 8'hDD, 1'b1, 1'b1);
    // reset mid-word discards remaining beats
    add(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b0);
    add(1'b1, 1'b1, 32'h55555555, 1'b1, 1'b0, 1'b1, 8'hCC, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h55555555, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    reset = 1'b1; valid_in = 1'b0; data_in = 32'h0; ready_out = 1'b1;
    valid_in1 = 1'b0; data_in1 = 32'h0; ready_out1 = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; valid_in = tbl[i].vi; data_in = tbl[i].din; ready_out = tbl[i].ro;
      #1;
      check($sformatf("vec%0d.ready_in", i), ready_in, tbl[i].e_rdy);
      check($sformatf("vec%0d.valid_out", i), valid_out, tbl[i].e_vo);
      check($sformatf("vec%0d.last_out", i), last_out, tbl[i].e_last);
      if (tbl[i].cd) begin
        check($sformatf("vec%0d.data_out", i), data_out, tbl[i].e_do);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; valid_in = 1'b0; ready_out = 1'b1;

    // MS-slice-first instance
    valid_in1 = 1'b1; data_in1 = 32'h11223344; ready_out1 = 1'b1;
    #1;
    check("msb.ready_in", ready_in1, 1'b1);
    check("msb.idle_valid", valid_out1, 1'b0);
    @(posedge clk); #1;
    valid_in1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("msb.beat%0d.valid", k), valid_out1, 1'b1);
      check($sformatf("msb.beat%0d.data", k), data_out1, msb_exp[k]);
      check($sformatf("msb.beat%0d.last", k), last_out1, (k == 3) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    check("msb.done_valid", valid_out1, 1'b0);

    // randomized handshakes against beat queue model
    for (int c = 0; c < 500; c++) begin
      valid_in  = ($urandom_range(0, 9) < 6);
      data_in   = $urandom();
      ready_out = ($urandom_range(0, 9) < 7);
      #1;
      exp_rdy = (q.size() == 0) || ((q.size() == 1) && ready_out);
      check("rnd.valid_out", valid_out, (q.size() != 0) ? 1'b1 : 1'b0);
      check("rnd.ready_in", ready_in, exp_rdy);
      if (q.size() != 0) begin
        check("rnd.data_out", data_out, q[0].d);
        check("rnd.last_out", last_out, q[0].l);
        if (ready_out) begin
          if (valid_out && last_out) lasts_dut++;
          if (q[0].l) lasts_model++;
          void'(q.pop_front());
        end
      end else begin
        check("rnd.idle_last", last_out, 1'b0);
      end
      if (valid_in && exp_rdy) begin
        for (int k = 0; k < 4; k++) begin
          beat_t b;
          b.d = 8'((data_in >> (8 * k)) & 32'hFF);
          b.l = (k == 3);
          q.push_back(b);
        end
      end
      @(posedge clk); #1;
    end

    valid_in = 1'b0; ready_out = 1'b1;
    guard = 0;
    while ((q.size() != 0) && (guard < 16)) begin
      #1;
      check("drain.data_out", data_out, q[0].d);
      check("drain.last_out", last_out, q[0].l);
      if (valid_out && last_out) lasts_dut++;
      if (q[0].l) lasts_model++;
      void'(q.pop_front());
      guard++;
      @(posedge clk); #1;
    end
    check("drain.queue_empty", q.size(), 0);
    check("drain.valid_out", valid_out, 1'b0);
    check("rnd.last_count", lasts_dut, lasts_model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_serializer.md
RV_SERIALIZER -- requirements
Module: rv_serializer

Interface
REQ-001 The module SHALL have parameter IN_WIDTH, default 32, giving the wide input word width in bits.
REQ-002 The module SHALL have parameter OUT_WIDTH, default 8, giving the narrow output beat width in bits.
REQ-003 The module SHALL have parameter LSB_FIRST, default 1, where 1 emits bits [OUT_WIDTH-1:0] first and 0 emits the MS slice first.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The module SHALL have port valid_in, input, 1 bit, upstream word valid.
REQ-007 The module SHALL have port data_in, input, IN_WIDTH bits, upstream word.
REQ-008 The module SHALL have port ready_in, output, 1 bit, module accepts a word this cycle.
REQ-009 The module SHALL have port valid_out, output, 1 bit, beat on data_out is valid.
REQ-010 The module SHALL have port data_out, output, OUT_WIDTH bits, current beat.
REQ-011 The module SHALL have port last_out, output, 1 bit, current beat is the final beat of its word.
REQ-012 The module SHALL have port ready_out, input, 1 bit, downstream accepts the beat this cycle.

Function
REQ-013 RATIO = IN_WIDTH/OUT_WIDTH; elaboration SHALL fail if IN_WIDTH is not an exact multiple of OUT_WIDTH or RATIO < 2.
REQ-014 Input handshake SHALL occur when valid_in && ready_in; output handshake SHALL occur when valid_out && ready_out.
REQ-015 State machine SHALL have two states: IDLE (no word held) and BUSY (word held, beats pending).
REQ-016 The module SHALL keep a word register and a beat counter of width clog2(RATIO), range 0..RATIO-1.
REQ-017 In IDLE: ready_in = 1, valid_out = 0; on input handshake, the module SHALL capture data_in, set count to 0 and go to BUSY.
REQ-018 In BUSY: valid_out = 1; data_out SHALL be slice[count] of the held word (slice 0 = LS slice if LSB_FIRST=1, MS slice otherwise).
REQ-019 last_out SHALL be 1 iff state is BUSY and count == RATIO-1; otherwise 0.
REQ-020 In BUSY, an output handshake with count < RATIO-1 SHALL increment count; without an output handshake, count, word and data_out SHALL hold.
REQ-021 In BUSY, ready_in SHALL be combinationally (last_out && ready_out); ready_in SHALL not depend on valid_in.
REQ-022 Last beat accepted with no input handshake: next state SHALL be IDLE, count 0.
REQ-023 Last beat accepted with a simultaneous input handshake: the module SHALL load the new word, set count 0 and stay BUSY, with no bubble cycle.
REQ-024 Latency: a word accepted in cycle T SHALL present its first beat in cycle T+1; sustained throughput SHALL be one beat per cycle.
REQ-025 valid_out and data_out SHALL depend only on registered state; valid_in SHALL not reach any output combinationally.
REQ-026 Once valid_out is asserted, it SHALL not drop and data_out SHALL not change until the output handshake.

Reset
REQ-027 While reset = 1 at a rising edge, the module SHALL enter IDLE, clear count to 0 and clear the word register to 0.
REQ-028 While reset is high, ready_in SHALL be 0 and no input handshake SHALL be recognised.
REQ-029 After reset, outputs SHALL be valid_out = 0, last_out = 0, data_out = 0, and ready_in = 1 from the first cycle with reset low.
REQ-030 Reset asserted mid-word SHALL discard the remaining beats; no beat of that word SHALL appear after reset releases.

Verification
REQ-031 Single word: defaults, ready_out = 1, word 0xDDCCBBAA accepted at cycle T -> beats AA, BB, CC, DD at T+1..T+4; last_out only with DD; IDLE at T+5.
REQ-032 Back-to-back: valid_in held with words 0x03020100 then 0x07060504, ready_out = 1 -> 8 consecutive beats 00..07 with no bubble; ready_in high only in IDLE and on the cycle of beat 03.
REQ-033 Backpressure: ready_out = 0 for 3 cycles during beat BB -> valid_out stays 1 and data_out stays BB; beat CC follows once ready_out = 1; no beat lost or duplicated.
REQ-034 LSB_FIRST = 0 with word 0x11223344 -> beats 11, 22, 33, 44, last_out with 44.
REQ-035 Reset mid-word: reset for 1 cycle after beat BB accepted -> valid_out = 0 and data_out = 0 next cycle; a new word 0x55555555 then yields four 55 beats only.
REQ-036 Random stimulus: random valid_in/ready_out; scoreboard checks beat order equals word slice order, exactly one last_out per word, and the stability rule of REQ-026.
